// File: rtl/xilly_hls_stream_bridge.sv
// Bridge between a Xillybus host stream pair and an HLS core using ap_fifo
// ports. Host words pass through an input FIFO and a one-word prefetch
// register to the HLS core; HLS results pass through an output FIFO back to
// the host. A small state machine holds the HLS core in reset until both
// host streams are open and signals end-of-file once the core has finished
// and its results have been read out.
module xilly_hls_stream_bridge #(
  parameter int DATA_W    = 32,
  parameter int IN_DEPTH  = 512,
  parameter int OUT_DEPTH = 512
) (
  input  logic              bus_clk,
  input  logic              bus_rst_n,
  input  logic [DATA_W-1:0] user_w_data,
  input  logic              user_w_wren,
  output logic              user_w_full,
  input  logic              user_w_open,
  input  logic              user_r_rden,
  output logic [DATA_W-1:0] user_r_data,
  output logic              user_r_empty,
  output logic              user_r_eof,
  input  logic              user_r_open,
  output logic [DATA_W-1:0] in_r_dout,
  output logic              in_r_empty_n,
  input  logic              in_r_read,
  input  logic [DATA_W-1:0] out_r_din,
  output logic              out_r_full_n,
  input  logic              out_r_write,
  output logic              hls_rst,
  input  logic              hls_done,
  output logic [31:0]       words_in,
  output logic [31:0]       words_out
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_EOF} state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------- input path
  logic [DATA_W-1:0] in_mem [IN_DEPTH];
  logic [IAW:0]      in_wr_ptr, in_rd_ptr;
  logic              in_empty, in_full, in_push, in_pop, in_flush;
  logic              pf_vld, pf_take;
  logic [DATA_W-1:0] pf_data;

  assign in_flush = !user_w_open;
  assign in_empty = (in_wr_ptr == in_rd_ptr);
  assign in_full  = (in_wr_ptr[IAW] != in_rd_ptr[IAW]) &&
                    (in_wr_ptr[IAW-1:0] == in_rd_ptr[IAW-1:0]);
  // A read is only meaningful while the prefetch register holds a word.
  assign pf_take  = pf_vld && in_r_read;
  // The register refills whenever it is empty or being emptied this cycle.
  assign in_pop   = !in_flush && !in_empty && (!pf_vld || pf_take);
  // A full FIFO still takes a word when it pops one in the same cycle.
  assign in_push  = !in_flush && user_w_wren && (!in_full || in_pop);

  assign user_w_full  = in_full;
  assign in_r_empty_n = pf_vld;
  assign in_r_dout    = pf_data;

  // Input FIFO pointers; closing the host write stream empties the FIFO.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
    end else if (in_flush) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
    end else begin
      if (in_push) in_wr_ptr <= in_wr_ptr + 1'b1;
      if (in_pop)  in_rd_ptr <= in_rd_ptr + 1'b1;
    end
  end

  // Input FIFO storage.
  always_ff @(posedge bus_clk) begin
    if (in_push) in_mem[in_wr_ptr[IAW-1:0]] <= user_w_data;
  end

  // Prefetch register presenting the head word to the HLS core.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      pf_vld  <= 1'b0;
      pf_data <= '0;
    end else if (in_flush) begin
      pf_vld  <= 1'b0;
    end else if (in_pop) begin
      pf_vld  <= 1'b1;
      pf_data <= in_mem[in_rd_ptr[IAW-1:0]];
    end else if (pf_take) begin
      pf_vld  <= 1'b0;
    end
  end

  // --------------------------------------------------------------- output path
  logic [DATA_W-1:0] out_mem [OUT_DEPTH];
  logic [OAW:0]      out_wr_ptr, out_rd_ptr;
  logic              out_empty, out_full, out_push, out_pop, out_flush;

  assign out_flush = !user_r_open;
  assign out_empty = (out_wr_ptr == out_rd_ptr);
  assign out_full  = (out_wr_ptr[OAW] != out_rd_ptr[OAW]) &&
                     (out_wr_ptr[OAW-1:0] == out_rd_ptr[OAW-1:0]);
  assign out_pop   = !out_flush && user_r_rden && !out_empty;
  assign out_push  = !out_flush && out_r_write && (!out_full || out_pop);

  assign user_r_empty = out_empty;
  assign out_r_full_n = !out_full;

  // Output FIFO pointers; closing the host read stream empties the FIFO.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
    end else if (out_flush) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
    end else begin
      if (out_push) out_wr_ptr <= out_wr_ptr + 1'b1;
      if (out_pop)  out_rd_ptr <= out_rd_ptr + 1'b1;
    end
  end

  // Output FIFO storage.
  always_ff @(posedge bus_clk) begin
    if (out_push) out_mem[out_wr_ptr[OAW-1:0]] <= out_r_din;
  end

  // Registered host read data, valid the cycle after an accepted rden.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      user_r_data <= '0;
    end else if (out_pop) begin
      user_r_data <= out_mem[out_rd_ptr[OAW-1:0]];
    end
  end

  // --------------------------------------------------------------- control FSM
  // State register.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; a closed read stream always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (user_w_open && user_r_open) state_d = ST_RUN;
      ST_RUN: begin
        if (!user_w_open)  state_d = ST_IDLE;
        else if (hls_done) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (out_empty) state_d = ST_EOF;
      ST_EOF:   state_d = ST_EOF;
      default:  state_d = ST_IDLE;
    endcase
    if (!user_r_open) state_d = ST_IDLE;
  end

  assign hls_rst    = (state_q == ST_IDLE);
  assign user_r_eof = (state_q == ST_EOF) && out_empty;

  // Transfer counters, held at zero while idle or on the way into idle.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      words_in  <= '0;
      words_out <= '0;
    end else if (state_q == ST_IDLE || state_d == ST_IDLE) begin
      words_in  <= '0;
      words_out <= '0;
    end else begin
      if (pf_take)  words_in  <= words_in + 32'd1;
      if (out_push) words_out <= words_out + 32'd1;
    end
  end

endmodule

// File: tb/tb_xilly_hls_stream_bridge.sv
// Self-checking bench for xilly_hls_stream_bridge with small FIFO depths.
module tb_xilly_hls_stream_bridge;

  localparam int DW = 32;
  localparam int ID = 8;
  localparam int OD = 8;

  logic          bus_clk, bus_rst_n;
  logic [DW-1:0] user_w_data, user_r_data, in_r_dout, out_r_din;
  logic          user_w_wren, user_w_full, user_w_open;
  logic          user_r_rden, user_r_empty, user_r_eof, user_r_open;
  logic          in_r_empty_n, in_r_read, out_r_full_n, out_r_write;
  logic          hls_rst, hls_done;
  logic [31:0]   words_in, words_out;

  xilly_hls_stream_bridge #(.DATA_W(DW), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
    .user_w_data(user_w_data), .user_w_wren(user_w_wren),
    .user_w_full(user_w_full), .user_w_open(user_w_open),
    .user_r_rden(user_r_rden), .user_r_data(user_r_data),
    .user_r_empty(user_r_empty), .user_r_eof(user_r_eof),
    .user_r_open(user_r_open),
    .in_r_dout(in_r_dout), .in_r_empty_n(in_r_empty_n), .in_r_read(in_r_read),
    .out_r_din(out_r_din), .out_r_full_n(out_r_full_n), .out_r_write(out_r_write),
    .hls_rst(hls_rst), .hls_done(hls_done),
    .words_in(words_in), .words_out(words_out)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_w_full"},    user_w_full, 0);
    chk({tag, "_r_empty"},   user_r_empty, 1);
    chk({tag, "_r_eof"},     user_r_eof, 0);
    chk({tag, "_empty_n"},   in_r_empty_n, 0);
    chk({tag, "_full_n"},    out_r_full_n, 1);
    chk({tag, "_hls_rst"},   hls_rst, 1);
    chk({tag, "_r_data"},    user_r_data, 0);
    chk({tag, "_in_dout"},   in_r_dout, 0);
    chk({tag, "_words_in"},  words_in, 0);
    chk({tag, "_words_out"}, words_out, 0);
  endtask

  typedef struct {
    logic        wren;
    logic [31:0] wdata;
    logic        rd;
    logic        exp_vld;
    logic [31:0] exp_dout;
    logic [31:0] exp_win;
  } vec_t;

  vec_t        tbl [5];
  logic [31:0] in_q [$];
  logic [31:0] oq [$];
  logic [31:0] exp_v;
  logic        pend;
  logic [31:0] pend_v;
  int          idx, consumed, produced;

  initial begin
    tbl[0] = '{1'b1, 32'h11, 1'b1, 1'b0, 32'h0,  32'd0};
    tbl[1] = '{1'b1, 32'h22, 1'b1, 1'b1, 32'h11, 32'd0};
    tbl[2] = '{1'b1, 32'h33, 1'b1, 1'b1, 32'h22, 32'd1};
    tbl[3] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h33, 32'd2};
    tbl[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  32'd3};

    bus_rst_n = 1'b0;
    user_w_data = '0; user_w_wren = 1'b0; user_w_open = 1'b0;
    user_r_rden = 1'b0; user_r_open = 1'b0;
    in_r_read = 1'b0; out_r_din = '0; out_r_write = 1'b0; hls_done = 1'b0;
    tick(); tick();
    chk_reset_vals("rst");

    // Leave reset, open both streams: IDLE -> RUN.
    bus_rst_n = 1'b1;
    user_w_open = 1'b1; user_r_open = 1'b1;
    tick();
    tick();
    chk("run_hls_rst", hls_rst, 0);

    // Back-to-back delivery table.
    for (int i = 0; i < 5; i++) begin
      user_w_wren = tbl[i].wren;
      user_w_data = tbl[i].wdata;
      in_r_read   = tbl[i].rd;
      tick();
      chk($sformatf("tbl%0d_empty_n", i), in_r_empty_n, tbl[i].exp_vld);
      if (tbl[i].exp_vld) chk($sformatf("tbl%0d_dout", i), in_r_dout, tbl[i].exp_dout);
      chk($sformatf("tbl%0d_words_in", i), words_in, tbl[i].exp_win);
    end

    // Fill FIFO plus prefetch register with the HLS side stalled.
    in_r_read = 1'b0;
    user_w_wren = 1'b1;
    for (int k = 1; k <= ID + 2; k++) begin
      user_w_data = 32'h100 + 32'(k - 1);
      tick();
      chk($sformatf("fill_full_%0d", k), user_w_full, (k >= ID + 1) ? 1 : 0);
    end
    user_w_wren = 1'b0;
    in_r_read = 1'b1;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (in_r_empty_n) begin
        chk("fill_order", in_r_dout, 32'h100 + 32'(idx));
        idx++;
      end
      tick();
    end
    chk("fill_count", idx, ID + 1);
    chk("fill_empty_n", in_r_empty_n, 0);
    in_r_read = 1'b0;

    // Output FIFO full with simultaneous write and read.
    out_r_write = 1'b1;
    for (int i = 0; i < OD; i++) begin
      out_r_din = 32'h200 + 32'(i);
      oq.push_back(out_r_din);
      tick();
    end
    chk("ofull_full_n", out_r_full_n, 0);
    for (int i = 0; i < 10; i++) begin
      out_r_din = 32'h300 + 32'(i);
      oq.push_back(out_r_din);
      user_r_rden = 1'b1;
      exp_v = oq.pop_front();
      tick();
      chk("ofull_rw_data", user_r_data, exp_v);
      chk("ofull_rw_full_n", out_r_full_n, 0);
    end
    out_r_write = 1'b0;
    chk("ofull_words_out", words_out, OD + 10);
    for (int i = 0; i < OD; i++) begin
      exp_v = oq.pop_front();
      tick();
      chk("ofull_drain_data", user_r_data, exp_v);
    end
    user_r_rden = 1'b0;
    chk("ofull_drain_empty", user_r_empty, 1);

    // Result word, done, readout, end-of-file.
    out_r_write = 1'b1; out_r_din = 32'hA5;
    tick();
    out_r_write = 1'b0; hls_done = 1'b1;
    tick();
    hls_done = 1'b0;
    chk("eof_wait_eof", user_r_eof, 0);
    user_r_rden = 1'b1;
    tick();
    user_r_rden = 1'b0;
    chk("eof_data", user_r_data, 32'hA5);
    chk("eof_empty", user_r_empty, 1);
    tick();
    chk("eof_eof", user_r_eof, 1);
    chk("eof_eof_empty", user_r_empty, 1);
    user_w_open = 1'b0;
    tick();
    chk("eof_sticky", user_r_eof, 1);
    chk("eof_no_rst", hls_rst, 0);
    user_w_open = 1'b1;
    user_r_open = 1'b0;
    tick();
    chk("close_hls_rst", hls_rst, 1);
    chk("close_eof", user_r_eof, 0);
    user_r_open = 1'b1;
    tick();
    chk("reopen_run", hls_rst, 0);

    // Read stream dropped mid-run with output words buffered.
    in_r_read = 1'b1; user_w_wren = 1'b1;
    user_w_data = 32'h55; tick();
    user_w_data = 32'h66; tick();
    user_w_wren = 1'b0;
    tick(); tick(); tick();
    chk("drop_words_in", words_in, 2);
    in_r_read = 1'b0;
    out_r_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      out_r_din = 32'h400 + 32'(i);
      tick();
    end
    out_r_write = 1'b0;
    chk("drop_words_out", words_out, 5);
    user_r_open = 1'b0;
    tick();
    chk("drop_hls_rst", hls_rst, 1);
    chk("drop_words_in0", words_in, 0);
    chk("drop_words_out0", words_out, 0);
    chk("drop_r_empty", user_r_empty, 1);
    user_r_open = 1'b1;
    tick();
    chk("drop_reopen_empty", user_r_empty, 1);
    chk("drop_reopen_run", hls_rst, 0);

    // Randomized traffic on both paths against queue models.
    in_q.delete(); oq.delete();
    pend = 1'b0; consumed = 0; produced = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (pend) chk("rnd_out_data", user_r_data, pend_v);
      pend = 1'b0;
      if (in_r_empty_n) chk("rnd_in_spurious", (in_q.size() != 0), 1);
      if (!user_r_empty) chk("rnd_out_spurious", (oq.size() != 0), 1);
      if (user_w_full) chk("rnd_full_occ", (in_q.size() >= ID), 1);
      in_r_read = (c >= 2500) || ($urandom_range(0, 1) == 1);
      if (in_r_read && in_r_empty_n && in_q.size() != 0) begin
        chk("rnd_in_data", in_r_dout, in_q.pop_front());
        consumed++;
      end
      if (c < 2500 && $urandom_range(0, 2) != 0 && !user_w_full) begin
        user_w_wren = 1'b1; user_w_data = $urandom; in_q.push_back(user_w_data);
      end else begin
        user_w_wren = 1'b0;
      end
      if (c < 2500 && $urandom_range(0, 1) == 1 && out_r_full_n) begin
        out_r_write = 1'b1; out_r_din = $urandom; oq.push_back(out_r_din); produced++;
      end else begin
        out_r_write = 1'b0;
      end
      user_r_rden = ((c >= 2500) || ($urandom_range(0, 2) == 0)) && !user_r_empty;
      if (user_r_rden && oq.size() != 0) begin
        pend = 1'b1; pend_v = oq.pop_front();
      end
    end
    user_w_wren = 1'b0; out_r_write = 1'b0; user_r_rden = 1'b0; in_r_read = 1'b0;
    tick();
    if (pend) chk("rnd_out_data", user_r_data, pend_v);
    chk("rnd_in_left", in_q.size(), 0);
    chk("rnd_out_left", oq.size(), 0);
    chk("rnd_words_in", words_in, consumed);
    chk("rnd_words_out", words_out, produced);

    // Asynchronous reset between clock edges with words in flight.
    user_w_wren = 1'b1; out_r_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      user_w_data = 32'h700 + 32'(i); out_r_din = 32'h800 + 32'(i);
      tick();
    end
    user_w_wren = 1'b0; out_r_write = 1'b0;
    user_r_rden = 1'b1;
    tick();
    user_r_rden = 1'b0;
    #2;
    bus_rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    #1;
    bus_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst_after_empty_n", in_r_empty_n, 0);
      chk("arst_after_r_empty", user_r_empty, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/xilly_hls_stream_bridge.md
XILLY_HLS_STREAM_BRIDGE -- requirements
Module: xilly_hls_stream_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning stream word width for both directions (8, 16, 32 or 64).
REQ-002 SHALL have parameter IN_DEPTH, default 512, meaning host-to-HLS FIFO depth in words (power of two, at least 4).
REQ-003 SHALL have parameter OUT_DEPTH, default 512, meaning HLS-to-host FIFO depth in words (power of two, at least 4).
REQ-004 SHALL have ports: bus_clk  in  1  sole clock; bus_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: user_w_data  in  DATA_W; user_w_wren  in  1; user_w_full  out  1; user_w_open  in  1 (Xillybus host-to-FPGA stream).
REQ-006 SHALL have ports: user_r_rden  in  1; user_r_data  out  DATA_W; user_r_empty  out  1; user_r_eof  out  1; user_r_open  in  1 (Xillybus FPGA-to-host stream).
REQ-007 SHALL have ports: in_r_dout  out  DATA_W; in_r_empty_n  out  1; in_r_read  in  1 (HLS ap_fifo input side).
REQ-008 SHALL have ports: out_r_din  in  DATA_W; out_r_full_n  out  1; out_r_write  in  1 (HLS ap_fifo output side).
REQ-009 SHALL have ports: hls_rst  out  1  HLS core reset; hls_done  in  1  ap_done pulse; words_in  out  32  words delivered to HLS; words_out  out  32  words accepted from HLS.

Function
REQ-010 SHALL contain an IN_DEPTH-word input FIFO written on user_w_wren, with user_w_full = 1 when holding IN_DEPTH words; a write while full SHALL be dropped.
REQ-011 SHALL contain a one-word prefetch register behind the input FIFO driving in_r_dout/in_r_empty_n; it SHALL load when FIFO non-empty and (register empty or in_r_read in same cycle), giving back-to-back one-word-per-cycle delivery.
REQ-012 SHALL set in_r_empty_n 1 cycle after the first write into an empty FIFO and empty register (first-word latency 2 cycles from user_w_wren).
REQ-013 SHALL ignore in_r_read while in_r_empty_n = 0.
REQ-014 SHALL contain an OUT_DEPTH-word output FIFO written on out_r_write when out_r_full_n = 1; out_r_full_n = 0 when holding OUT_DEPTH words; a write while full SHALL be dropped.
REQ-015 SHALL present user_r_data exactly 1 cycle after a user_r_rden with user_r_empty = 0 (standard, non-fall-through read); user_r_rden while empty SHALL be ignored.
REQ-016 SHALL handle simultaneous read and write on either FIFO in one cycle, including at full and at empty, with occupancy unchanged when full/empty with both; pointers SHALL wrap modulo depth.
REQ-017 SHALL synchronously flush input FIFO and prefetch register in any cycle where user_w_open = 0; SHALL flush output FIFO in any cycle where user_r_open = 0.
REQ-018 SHALL drive hls_rst = 1 whenever state is IDLE (combinational from state register).
REQ-019 SHALL implement states IDLE, RUN, DRAIN, EOF with transitions: IDLE->RUN when user_w_open and user_r_open both 1; RUN->DRAIN on hls_done; DRAIN->EOF when output FIFO empty; any state->IDLE when user_r_open = 0; RUN->IDLE when user_w_open = 0.
REQ-020 SHALL hold user_r_eof = 1 only in EOF, asserted together with user_r_empty = 1; user_w_open falling in DRAIN or EOF SHALL NOT leave those states.
REQ-021 SHALL increment words_in on each accepted in_r_read and words_out on each accepted out_r_write, wrapping 2^32-1 to 0, both cleared in IDLE.
REQ-022 SHALL ignore hls_done outside RUN.

Reset
REQ-023 SHALL, on bus_rst_n = 0 regardless of clock, enter IDLE, empty both FIFOs and prefetch register, clear counters; outputs: user_w_full 0, user_r_empty 1, user_r_eof 0, in_r_empty_n 0, out_r_full_n 1, hls_rst 1, user_r_data 0, in_r_dout 0.
REQ-024 SHALL leave reset synchronously to bus_clk; reset asserted mid-transfer SHALL discard all buffered words.

Verification
REQ-025 Both opens 1, write 0x11,0x22,0x33 on consecutive cycles, in_r_read held 1 -> in_r_dout 0x11,0x22,0x33 on consecutive cycles, words_in = 3.
REQ-026 Write IN_DEPTH+2 words with in_r_read = 0 -> user_w_full rises after word IN_DEPTH+1 (IN_DEPTH FIFO + 1 register), extra word dropped, readout sequence intact.
REQ-027 HLS writes 0xA5 then hls_done, host reads -> user_r_data = 0xA5 one cycle after rden, then user_r_empty = 1 and user_r_eof = 1 next cycle.
REQ-028 Output FIFO full with simultaneous out_r_write and user_r_rden for 10 cycles -> out_r_full_n stays 0, no word lost, words_out counts 10.
REQ-029 user_r_open dropped in RUN with 5 words buffered -> IDLE next cycle, hls_rst = 1, counters 0, user_r_empty = 1 after reopen.
REQ-030 bus_rst_n pulsed low between clock edges mid-stream -> all outputs at REQ-023 values immediately, no in_r_empty_n after release until new write.
